// File: rtl/seven_seg_module_if.sv
// Segment-decoder bus: the value/control inputs and the registered segment
// vector for one digit of the display.
//   num       [3:0]  hex value to show
//   dp               1 = decimal point lit
//   blank            1 = all segments and dp off
//   lamp_test        1 = all segments and dp on (wins over blank)
//   seg       [7:0]  segment drive, {dp, g, f, e, d, c, b, a}
// master: the logic producing the digit; slave: the decoder.
interface seven_seg_module_if;
    logic [3:0] num;
    logic       dp;
    logic       blank;
    logic       lamp_test;
    logic [7:0] seg;

    modport master (
        output num,
        output dp,
        output blank,
        output lamp_test,
        input  seg
    );

    modport slave (
        input  num,
        input  dp,
        input  blank,
        input  lamp_test,
        output seg
    );
endinterface

// File: rtl/seven_seg_module.sv
// Single-digit hex to seven-segment decoder with a registered output.
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset; forces seg to all-off at once
//   seg_if  seven_seg_module_if.slave (num, dp, blank, lamp_test in; seg out)
// Parameter:
//   ACTIVE_LOW  1 = a lit segment is driven 0 (common-anode board), 0 = driven 1
// The output register is the only state; inputs reach seg one clock later.
module seven_seg_module #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_module_if.slave   seg_if
);

    localparam logic [7:0] POL_MASK = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0] ALL_OFF  = POL_MASK;
    localparam logic [7:0] ALL_ON   = ~POL_MASK;

    logic [6:0] pattern_hi;
    logic [7:0] seg_d;
    logic [7:0] seg_q;

    // Active-high g..a pattern; every code 0-F is a real glyph.
    always_comb begin
        pattern_hi = 7'h00;
        case (seg_if.num)
            4'h0: pattern_hi = 7'h3F;
            4'h1: pattern_hi = 7'h06;
            4'h2: pattern_hi = 7'h5B;
            4'h3: pattern_hi = 7'h4F;
            4'h4: pattern_hi = 7'h66;
            4'h5: pattern_hi = 7'h6D;
            4'h6: pattern_hi = 7'h7D;
            4'h7: pattern_hi = 7'h07;
            4'h8: pattern_hi = 7'h7F;
            4'h9: pattern_hi = 7'h6F;
            4'hA: pattern_hi = 7'h77;
            4'hB: pattern_hi = 7'h7C;
            4'hC: pattern_hi = 7'h39;
            4'hD: pattern_hi = 7'h5E;
            4'hE: pattern_hi = 7'h79;
            4'hF: pattern_hi = 7'h71;
        endcase
    end

    // lamp_test overrides blank so a blanked digit can still be lamp-checked.
    always_comb begin
        seg_d = ALL_OFF;
        if (seg_if.lamp_test) begin
            seg_d = ALL_ON;
        end else if (seg_if.blank) begin
            seg_d = ALL_OFF;
        end else begin
            seg_d = {seg_if.dp, pattern_hi} ^ POL_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= ALL_OFF;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_if.seg = seg_q;

endmodule

// File: tb/tb_seven_seg_module.sv
module tb_seven_seg_module;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [7:0] last_exp;

    seven_seg_module_if bus ();

    seven_seg_module #(.ACTIVE_LOW(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seg_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: seg=%h expected %h", tag, obs, exp);
        end
    endtask

    // Drive new inputs away from the clock edge, confirm seg has not moved
    // yet, then confirm the new value one rising edge later.
    task automatic step(input logic [3:0] n, input logic d, input logic b,
                        input logic lt, input logic [7:0] exp, input string tag);
        @(negedge clk);
        bus.num       = n;
        bus.dp        = d;
        bus.blank     = b;
        bus.lamp_test = lt;
        #1 check({tag, "_before_edge"}, bus.seg, last_exp);
        @(posedge clk);
        #1 check(tag, bus.seg, exp);
        last_exp = exp;
    endtask

    logic [7:0] sweep_exp [0:10];

    initial begin
        checks = 0;
        errors = 0;
        sweep_exp = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                      8'h82, 8'hF8, 8'h80, 8'h90, 8'h88};

        bus.num       = 4'h8;
        bus.dp        = 1'b0;
        bus.blank     = 1'b0;
        bus.lamp_test = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_async", bus.seg, 8'hFF);
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", bus.seg, 8'hFF);
        end

        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset_release_before_edge", bus.seg, 8'hFF);
        @(posedge clk);
        #1 check("reset_release_num8", bus.seg, 8'h80);
        last_exp = 8'h80;

        for (int i = 0; i <= 10; i++) begin
            step(4'(i), 1'b0, 1'b0, 1'b0, sweep_exp[i], $sformatf("sweep_%0h", i));
            repeat (9) @(posedge clk);
            #1 check($sformatf("sweep_hold_%0h", i), bus.seg, sweep_exp[i]);
        end

        step(4'hB, 1'b0, 1'b0, 1'b0, 8'h83, "hex_b");
        step(4'hC, 1'b0, 1'b0, 1'b0, 8'hC6, "hex_c");
        step(4'hD, 1'b0, 1'b0, 1'b0, 8'hA1, "hex_d");
        step(4'hE, 1'b0, 1'b0, 1'b0, 8'h86, "hex_e");
        step(4'hF, 1'b0, 1'b0, 1'b0, 8'h8E, "hex_f");
        step(4'h0, 1'b0, 1'b0, 1'b0, 8'hC0, "wrap_f_to_0");
        step(4'h0, 1'b1, 1'b0, 1'b0, 8'h40, "dp_num0");

        step(4'h5, 1'b1, 1'b0, 1'b0, 8'h12, "dp_on_num5");
        step(4'h5, 1'b0, 1'b0, 1'b0, 8'h92, "dp_off_num5");

        step(4'h3, 1'b0, 1'b1, 1'b0, 8'hFF, "blank");
        step(4'h3, 1'b0, 1'b1, 1'b1, 8'h00, "lamp_over_blank");
        step(4'h3, 1'b0, 1'b0, 1'b0, 8'hB0, "prio_release");
        step(4'h9, 1'b1, 1'b1, 1'b0, 8'hFF, "blank_with_dp");
        step(4'h1, 1'b0, 1'b0, 1'b1, 8'h00, "lamp_only");

        step(4'h7, 1'b0, 1'b0, 1'b0, 8'hF8, "pre_reset_num7");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midrun_reset_async", bus.seg, 8'hFF);
        @(posedge clk);
        #1 check("midrun_reset_ignores_clk", bus.seg, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrun_release_before_edge", bus.seg, 8'hFF);
        @(posedge clk);
        #1 check("midrun_release_num7", bus.seg, 8'hF8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_module.md
Name: seven_seg_module

Overview:
Single-digit hexadecimal-to-seven-segment decoder with a registered output, driving one digit of the board's common-anode display. Converts a 4-bit value (0-F) plus decimal-point, blank and lamp-test controls into an 8-bit segment vector. Sits between the traffic-signal FSM/counter logic and the display pins.

Parameters:
ACTIVE_LOW, 1, 1 = segment on is driven 0 (board default); 0 = segment on is driven 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
num  input  4  value to display, 0x0-0xF.
dp  input  1  1 = decimal point lit.
blank  input  1  1 = all segments and dp off.
lamp_test  input  1  1 = all segments and dp on.
seg  output  8  segment drive; seg[0]=a, seg[1]=b, seg[2]=c, seg[3]=d, seg[4]=e, seg[5]=f, seg[6]=g, seg[7]=dp.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). Clock port is clk.
- Reset: seg forced immediately (asynchronously) to all-off: 8'hFF when ACTIVE_LOW=1, 8'h00 when ACTIVE_LOW=0. Stays all-off until the first rising clk after rst_n deasserts.
- Latency: seg is a register. Inputs are sampled on rising clk and reflected on seg after that edge (1-cycle latency). No combinational path from inputs to seg.
- Priority: lamp_test > blank > normal decode.
- Normal decode, active-high pattern for bits g..a:
  0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - bit7 = dp.
  - With ACTIVE_LOW=1, the full 8-bit vector is inverted.
- ACTIVE_LOW=1 results with dp=0:
  0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- dp=1 clears bit7 in active-low mode, e.g. num=0 gives 40.
- blank=1 (lamp_test=0): seg = all-off, regardless of num and dp.
- lamp_test=1: seg = all-on, including dp (8'h00 active-low).
- All 16 codes are defined; no don't-care or default output for any num value.
- num wrapping F->0 is the caller's concern; the decoder simply decodes 0 on the next edge.
- Reset asserted mid-operation: seg goes all-off immediately and ignores clk while rst_n=0.
- No other state; the block holds no memory beyond the output register.

Test Plan:
- Reset: rst_n=0 with num=8 and clk running -> seg=FF throughout. Release rst_n -> seg=80 after the first rising edge.
- Sweep: num stepped 0 through A, holding each value 100 ns (10 clocks), dp=0 -> seg C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, each appearing one clock after the num change.
- Upper hex: num=B, C, D, E, F -> 83, C6, A1, 86, 8E. Then num=0 after F -> C0.
- Decimal point: num=5, dp=1 -> 12. Set dp=0 -> 92 on the next edge.
- Priority:
  - num=3, blank=1 -> FF.
  - Add lamp_test=1 -> 00.
  - Drop both -> B0.
  - Each change takes effect one edge later.
- Async reset mid-run: num=7 and seg=F8, pulse rst_n low between clock edges -> seg=FF immediately, without waiting for clk. Release -> F8 after the next edge.
